// File: rtl/clk_div_monitor_pkg.sv
// rtl/clk_div_monitor_pkg.sv - shared lane state encoding and error-counter constants
package clk_div_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } lane_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    function automatic logic [1:0] count_events(input logic [2:0] ev);
        return 2'(ev[0]) + 2'(ev[1]) + 2'(ev[2]);
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - control, clocks-under-test and status bundle for the monitor
interface clk_div_monitor_if;
    logic       enable;
    logic [2:0] clks;
    logic       clear_err;
    logic [2:0] locked;
    logic [2:0] error;
    logic [7:0] err_count;

    modport master (output enable, clks, clear_err, input locked, error, err_count);
    modport slave  (input enable, clks, clear_err, output locked, error, err_count);
endinterface

// File: rtl/clk_lane_check.sv
// rtl/clk_lane_check.sv - single-lane run-length checker with acquire/track/lock FSM
module clk_lane_check
    import clk_div_monitor_pkg::*;
#(
    parameter int H         = 1,
    parameter int LOCK_RUNS = 4,
    parameter int CW        = 8
) (
    input  logic clk,
    input  logic reset_L,
    input  logic enable,
    input  logic clk_in,
    output logic locked,
    output logic err_event
);
    localparam int GW = $clog2(LOCK_RUNS + 1);
    localparam logic [CW-1:0] RUN_H     = CW'(H);
    localparam logic [CW-1:0] RUN_STUCK = CW'(H + 1);
    localparam logic [CW-1:0] RUN_MAX   = '1;
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_RUNS);

    logic          samp, samp_prev;
    logic [CW-1:0] run;
    logic [GW-1:0] good, good_nxt;
    lane_state_t   state, state_nxt;
    logic          trans, run_ok, run_bad;

    assign trans   = samp ^ samp_prev;
    assign run_ok  = trans && (run == RUN_H);
    // a missing edge counts as bad as soon as the run overshoots by one cycle
    assign run_bad = trans ? (run != RUN_H) : (run == RUN_STUCK);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            samp      <= 1'b0;
            samp_prev <= 1'b0;
            run       <= '0;
            state     <= ST_IDLE;
            good      <= '0;
        end else begin
            samp      <= clk_in;
            samp_prev <= samp;
            if (trans)
                run <= CW'(1);
            else if (run != RUN_MAX)
                run <= run + CW'(1);
            state     <= state_nxt;
            good      <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        err_event = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_ACQ;
                ST_ACQ: begin
                    if (trans) begin
                        state_nxt = ST_TRACK;
                        good_nxt  = '0;
                    end
                end
                ST_TRACK: begin
                    if (run_ok) begin
                        good_nxt = good + GW'(1);
                        if (good + GW'(1) == GOOD_LOCK)
                            state_nxt = ST_LOCKED;
                    end else if (run_bad) begin
                        good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (run_bad) begin
                        err_event = 1'b1;
                        state_nxt = ST_ACQ;
                    end
                end
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - three-lane divided-clock checker with sticky flags and saturating error count
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int DIV0      = 2,
    parameter int DIV1      = 4,
    parameter int DIV2      = 8,
    parameter int LOCK_RUNS = 4,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    clk_div_monitor_if.slave  mon
);
    logic [2:0] lane_locked;
    logic [2:0] ev;
    logic [2:0] error_q;
    logic [7:0] count_q;
    logic [1:0] n_ev;
    logic [8:0] sum;

    clk_lane_check #(.H(DIV0 / 2), .LOCK_RUNS(LOCK_RUNS), .CW(CW)) u_lane0 (
        .clk(clk), .reset_L(reset_L), .enable(mon.enable), .clk_in(mon.clks[0]),
        .locked(lane_locked[0]), .err_event(ev[0]));
    clk_lane_check #(.H(DIV1 / 2), .LOCK_RUNS(LOCK_RUNS), .CW(CW)) u_lane1 (
        .clk(clk), .reset_L(reset_L), .enable(mon.enable), .clk_in(mon.clks[1]),
        .locked(lane_locked[1]), .err_event(ev[1]));
    clk_lane_check #(.H(DIV2 / 2), .LOCK_RUNS(LOCK_RUNS), .CW(CW)) u_lane2 (
        .clk(clk), .reset_L(reset_L), .enable(mon.enable), .clk_in(mon.clks[2]),
        .locked(lane_locked[2]), .err_event(ev[2]));

    assign n_ev = count_events(ev);
    assign sum  = {1'b0, count_q} + 9'(n_ev);

    // clearing still records whatever failed in the same cycle
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_q <= '0;
            count_q <= '0;
        end else if (mon.clear_err) begin
            error_q <= ev;
            count_q <= {6'b0, n_ev};
        end else begin
            error_q <= error_q | ev;
            count_q <= sum[8] ? ERR_CNT_MAX : sum[7:0];
        end
    end

    assign mon.locked    = lane_locked;
    assign mon.error     = error_q;
    assign mon.err_count = count_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed bench with a timestamp-based reference model for clk_div_monitor
module tb_clk_div_monitor;
    localparam int LOCK_RUNS = 4;

    logic clk;
    logic reset_L;
    clk_div_monitor_if mon();

    clk_div_monitor #(.DIV0(2), .DIV1(4), .DIV2(8), .LOCK_RUNS(LOCK_RUNS), .CW(8)) dut (
        .clk(clk), .reset_L(reset_L), .mon(mon));

    initial begin
        clk = 1'b0;
        forever #45 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: runs measured as cycle distance between observed edges
    int         hh[3] = '{1, 2, 4};
    int         m_mode[3];
    int         m_good[3];
    int         m_last[3];
    int         m_cyc = 0;
    logic [2:0] m_s = 3'b0, m_sp = 3'b0;
    logic [2:0] exp_locked = 3'b0, exp_error = 3'b0;
    int         exp_count = 0;
    logic [2:0] m_ev;
    int         m_run, m_nev;
    bit         m_tr, m_bad;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int n = 0; n < 3; n++) begin
                m_mode[n] = 0; m_good[n] = 0; m_last[n] = 0;
            end
            m_cyc = 0; m_s = 3'b0; m_sp = 3'b0;
            exp_locked = 3'b0; exp_error = 3'b0; exp_count = 0;
        end else begin
            m_ev = 3'b0;
            for (int n = 0; n < 3; n++) begin
                m_tr  = (m_s[n] != m_sp[n]);
                m_run = m_cyc - m_last[n];
                if (m_run > 255) m_run = 255;
                m_bad = m_tr ? (m_run != hh[n]) : (m_run == hh[n] + 1);
                if (!mon.enable) m_mode[n] = 0;
                else if (m_mode[n] == 0) m_mode[n] = 1;
                else if (m_mode[n] == 1) begin
                    if (m_tr) begin m_mode[n] = 2; m_good[n] = 0; end
                end else if (m_mode[n] == 2) begin
                    if (m_tr && m_run == hh[n]) begin
                        m_good[n]++;
                        if (m_good[n] == LOCK_RUNS) m_mode[n] = 3;
                    end else if (m_bad) m_good[n] = 0;
                end else if (m_bad) begin
                    m_ev[n] = 1'b1;
                    m_mode[n] = 1;
                end
                if (m_tr) m_last[n] = m_cyc;
            end
            m_nev = int'(m_ev[0]) + int'(m_ev[1]) + int'(m_ev[2]);
            if (mon.clear_err) begin
                exp_error = m_ev;
                exp_count = m_nev;
            end else begin
                exp_error = exp_error | m_ev;
                exp_count = (exp_count + m_nev > 255) ? 255 : exp_count + m_nev;
            end
            m_sp = m_s;
            m_s  = mon.clks;
            m_cyc++;
            for (int n = 0; n < 3; n++) exp_locked[n] = (m_mode[n] == 3);
        end
    end

    always @(negedge clk) begin
        chk("model_locked", int'(mon.locked), int'(exp_locked));
        chk("model_error", int'(mon.error), int'(exp_error));
        chk("model_err_count", int'(mon.err_count), exp_count);
    end

    // stimulus: ideal generator from a free-running count, with fault overlays
    logic [31:0] gcnt = 0;
    logic [2:0]  clk_drv = 3'b0;
    logic [2:0]  hold = 3'b0, force_hi = 3'b0, glitch = 3'b0;
    logic        en = 1'b0, clr = 1'b0;

    task automatic cycle();
        logic [2:0] nxt;
        @(posedge clk);
        #1;
        gcnt = gcnt + 1;
        nxt  = gcnt[2:0];
        nxt  = (nxt & ~hold) | (clk_drv & hold);
        nxt  = (nxt | force_hi) ^ glitch;
        clk_drv       = nxt;
        mon.clks      = nxt;
        mon.enable    = en;
        mon.clear_err = clr;
    endtask

    task automatic wait_locked(input int budget);
        int k;
        k = 0;
        while (mon.locked != 3'b111 && k < budget) begin
            cycle();
            k++;
        end
        chk("lock_wait", int'(mon.locked), 7);
    endtask

    initial begin
        reset_L = 1'b0;
        mon.enable = 1'b0;
        mon.clks = 3'b0;
        mon.clear_err = 1'b0;
        cycle();
        cycle();
        reset_L = 1'b1;
        chk("reset_locked", int'(mon.locked), 0);
        chk("reset_error", int'(mon.error), 0);
        chk("reset_count", int'(mon.err_count), 0);
        repeat (10) cycle();

        en = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("lane0_not_yet_locked", int'(mon.locked[0]), 0);
        cycle();
        chk("lane0_locked_at_6", int'(mon.locked[0]), 1);
        wait_locked(60);
        chk("lock_error", int'(mon.error), 0);
        chk("lock_count", int'(mon.err_count), 0);

        force_hi = 3'b010;
        repeat (5) cycle();
        force_hi = 3'b000;
        cycle();
        cycle();
        chk("stuck_error", int'(mon.error), 2);
        chk("stuck_count", int'(mon.err_count), 1);
        chk("stuck_locked", int'(mon.locked), 5);
        wait_locked(60);
        chk("relock_error_kept", int'(mon.error), 2);

        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        glitch = 3'b100;
        cycle();
        glitch = 3'b000;
        repeat (10) cycle();
        chk("glitch_error", int'(mon.error), 4);
        chk("glitch_count", int'(mon.err_count), 1);
        chk("glitch_others_locked", int'(mon.locked[1:0]), 3);

        wait_locked(60);
        en = 1'b0;
        cycle();
        cycle();
        chk("disable_locked", int'(mon.locked), 0);
        chk("disable_error_kept", int'(mon.error), 4);
        chk("disable_count_kept", int'(mon.err_count), 1);
        en = 1'b1;
        wait_locked(60);

        for (int k = 0; k < 8 && gcnt[1:0] != 2'd3; k++) cycle();
        cycle();
        repeat (3) cycle();
        hold = 3'b101;
        cycle();
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        chk("dual_clear_error", int'(mon.error), 5);
        chk("dual_clear_count", int'(mon.err_count), 2);
        hold = 3'b000;

        wait_locked(60);
        for (int k = 0; k < 300; k++) begin
            hold = 3'b001;
            repeat (3) cycle();
            hold = 3'b000;
            repeat (12) cycle();
        end
        repeat (30) cycle();
        chk("sat_count", int'(mon.err_count), 255);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        chk("sat_cleared_count", int'(mon.err_count), 0);
        chk("sat_cleared_error", int'(mon.error), 0);

        wait_locked(60);
        #10;
        reset_L = 1'b0;
        #1;
        chk("async_reset_locked", int'(mon.locked), 0);
        chk("async_reset_error", int'(mon.error), 0);
        chk("async_reset_count", int'(mon.err_count), 0);
        @(negedge clk);
        #5;
        reset_L = 1'b1;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
